instr_fetch: RTL and testbench

//  Instruction-fetch initiator for the MIPS CPU. Drives the instruction-memory read port
//  (Avalon-MM style: address/read/waitrequest/readdata) with sequential word PCs.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_buf.sv | 80 ++++++++
 rtl/instr_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS fetch front end.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN,
    HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Fetch buffer: small synchronous FIFO of {pc, word} with a registered head.
// Flush wins over push and pop; a push into an empty buffer is visible at the head next cycle.
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  fetch_entry_t               i_push_entry,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_full,
  output logic [$clog2(BUF_DEPTH):0] o_count,
  output logic                       o_head_valid,
  output fetch_entry_t               o_head
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_entry_t  r_mem [BUF_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_head_valid;
  fetch_entry_t  r_head;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_rd_next;
  logic          w_head_from_push;

  always_comb begin
    w_pop            = i_pop && r_head_valid && !i_flush;
    w_push           = i_push && ((r_count != DEPTH_C) || w_pop) && !i_flush;
    w_count_next     = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_next        = r_rd_ptr + AW'(w_pop);
    // The new head is the entry being pushed only when the buffer drains to empty this cycle.
    w_head_from_push = w_push && (r_count == CW'(w_pop));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
    end else if (i_flush) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_head_valid <= 1'b0;
    end else begin
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= r_wr_ptr + AW'(w_push);
      r_count      <= w_count_next;
      r_head_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_head <= w_head_from_push ? i_push_entry : r_mem[w_rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  assign o_full       = (r_count == DEPTH_C);
  assign o_count      = r_count;
  assign o_head_valid = r_head_valid;
  assign o_head       = r_head;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch initiator: sequential Avalon-MM word reads into a fetch buffer,
// with redirect, in-flight drain and sticky halt on redirect to address 0.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C = CW'(BUF_DEPTH - 1);
  localparam logic [31:0]   RESET_PC   = RESET_VECTOR & 32'hFFFF_FFFC;

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_avm_address;
  logic          r_avm_read;
  logic          r_halted;
  logic          r_boot;

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_full;
  logic [CW-1:0] w_count;
  logic          w_head_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_slot_free;
  logic          w_free_after_push;
  logic [31:0]   w_redir_pc;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_drain_target;

  always_comb begin
    w_accept          = r_avm_read && !avm_waitrequest;
    w_pop             = w_head_valid && instr_ready;
    w_push            = (r_state == REQ) && w_accept && !redirect_valid;
    w_push_entry      = '{pc: r_fetch_pc, word: avm_readdata};
    w_slot_free       = !w_full || w_pop;
    // Room left once this accepted word lands, counting a same-cycle pop.
    w_free_after_push = (w_count < DEPTH_M1_C) || (w_pop && (w_count < DEPTH_C));
    w_redir_pc        = redirect_pc & 32'hFFFF_FFFC;
    w_pc_plus4        = r_fetch_pc + 32'd4;
    w_drain_target    = redirect_valid ? w_redir_pc : r_fetch_pc;
  end

  fetch_buf #(
    .BUF_DEPTH(BUF_DEPTH)
  ) u_fetch_buf (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (redirect_valid),
    .o_full       (w_full),
    .o_count      (w_count),
    .o_head_valid (w_head_valid),
    .o_head       (w_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_fetch_pc    <= RESET_PC;
      r_avm_address <= RESET_PC;
      r_avm_read    <= 1'b0;
      r_halted      <= 1'b0;
      r_boot        <= 1'b1;
    end else begin
      r_boot <= 1'b0;
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            if (w_redir_pc == '0) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else begin
              r_state       <= REQ;
              r_avm_read    <= 1'b1;
              r_avm_address <= w_redir_pc;
            end
          end else if (r_boot && (RESET_PC == '0)) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else if (w_slot_free) begin
            r_state       <= REQ;
            r_avm_read    <= 1'b1;
            r_avm_address <= r_fetch_pc;
          end
        end

        REQ: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            if (avm_waitrequest) begin
              r_state <= DRAIN;
            end else if (w_redir_pc == '0) begin
              r_state    <= HALT;
              r_avm_read <= 1'b0;
              r_halted   <= 1'b1;
            end else begin
              r_avm_address <= w_redir_pc;
            end
          end else if (w_accept) begin
            r_fetch_pc <= w_pc_plus4;
            if (w_free_after_push) begin
              r_avm_address <= w_pc_plus4;
            end else begin
              r_state    <= IDLE;
              r_avm_read <= 1'b0;
            end
          end
        end

        // Old request stays on the bus until accepted; its data is dropped.
        DRAIN: begin
          r_fetch_pc <= w_drain_target;
          if (w_accept) begin
            if (w_drain_target == '0) begin
              r_state    <= HALT;
              r_avm_read <= 1'b0;
              r_halted   <= 1'b1;
            end else begin
              r_state       <= REQ;
              r_avm_address <= w_drain_target;
            end
          end
        end

        HALT: begin
          r_avm_read <= 1'b0;
          r_halted   <= 1'b1;
        end

        default: begin
          r_state    <= IDLE;
          r_avm_read <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = r_avm_address;
  assign avm_read    = r_avm_read;
  assign instr_valid = w_head_valid;
  assign instr       = w_head.word;
  assign instr_pc    = w_head.pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, stalls, backpressure, redirects, halt, reset.
module tb_instr_fetch;

  localparam logic [31:0] BASE = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  logic [31:0] z_address;
  logic        z_read;
  logic [31:0] z_readdata;
  logic        z_valid;
  logic [31:0] z_instr;
  logic [31:0] z_pc;
  logic        z_halted;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F ^ {a[15:0], a[31:16]};
  endfunction

  assign avm_readdata = mem_word(avm_address);
  assign z_readdata   = mem_word(z_address);

  instr_fetch #(
    .RESET_VECTOR(BASE),
    .BUF_DEPTH   (2)
  ) u_dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halted          (halted)
  );

  instr_fetch #(
    .RESET_VECTOR(32'h0000_0000),
    .BUF_DEPTH   (2)
  ) u_dut_zero (
    .clk             (clk),
    .reset_n         (reset_n),
    .avm_address     (z_address),
    .avm_read        (z_read),
    .avm_waitrequest (1'b0),
    .avm_readdata    (z_readdata),
    .instr_valid     (z_valid),
    .instr_ready     (1'b1),
    .instr           (z_instr),
    .instr_pc        (z_pc),
    .redirect_valid  (1'b0),
    .redirect_pc     (32'h0000_0000),
    .halted          (z_halted)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n         = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    avm_waitrequest = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n         = 1'b0;
    avm_waitrequest = 1'b0;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;

    // Reset state
    repeat (2) step();
    chk1("rst_read", avm_read, 1'b0);
    chk ("rst_addr", avm_address, BASE);
    chk1("rst_valid", instr_valid, 1'b0);
    chk ("rst_instr", instr, 32'h0);
    chk ("rst_pc", instr_pc, 32'h0);
    chk1("rst_halted", halted, 1'b0);
    chk1("z_rst_halted", z_halted, 1'b0);
    reset_n = 1'b1;

    // Zero-wait streaming, ready=1
    chk1("t1_idle_read", avm_read, 1'b0);
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      chk1("t1_read", avm_read, 1'b1);
      chk ("t1_addr", avm_address, BASE + 32'(4 * i));
      if (i == 0) begin
        chk1("t1_valid0", instr_valid, 1'b0);
        chk1("z_halted", z_halted, 1'b1);
        chk1("z_read", z_read, 1'b0);
        chk1("z_valid", z_valid, 1'b0);
        chk ("z_instr", z_instr, 32'h0);
        chk ("z_pc", z_pc, 32'h0);
      end else begin
        chk1("t1_valid", instr_valid, 1'b1);
        chk ("t1_pc", instr_pc, BASE + 32'(4 * (i - 1)));
        chk ("t1_instr", instr, mem_word(BASE + 32'(4 * (i - 1))));
      end
    end

    // waitrequest held 3 cycles on BASE+4
    apply_reset();
    step();
    step();
    chk1("t2_valid", instr_valid, 1'b1);
    chk ("t2_pc0", instr_pc, BASE);
    avm_waitrequest = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      chk1("t2_hold_read", avm_read, 1'b1);
      chk ("t2_hold_addr", avm_address, BASE + 32'd4);
      chk1("t2_hold_valid", instr_valid, 1'b0);
      chk ("t2_hold_pc", instr_pc, BASE);
    end
    avm_waitrequest = 1'b0;
    step();
    chk1("t2_valid1", instr_valid, 1'b1);
    chk ("t2_pc1", instr_pc, BASE + 32'd4);
    chk ("t2_instr1", instr, mem_word(BASE + 32'd4));
    step();
    chk ("t2_pc2", instr_pc, BASE + 32'd8);
    step();
    chk ("t2_pc3", instr_pc, BASE + 32'hC);

    // Backpressure: ready=0 for 10 cycles
    apply_reset();
    instr_ready = 1'b0;
    step();
    step();
    chk ("t3_addr1", avm_address, BASE + 32'd4);
    step();
    chk1("t3_read_off", avm_read, 1'b0);
    repeat (7) step();
    chk1("t3_read_still_off", avm_read, 1'b0);
    chk1("t3_valid", instr_valid, 1'b1);
    chk ("t3_pc", instr_pc, BASE);
    instr_ready = 1'b1;
    step();
    chk1("t3_resume_valid", instr_valid, 1'b1);
    chk ("t3_resume_pc", instr_pc, BASE + 32'd4);
    chk1("t3_resume_read", avm_read, 1'b1);
    chk ("t3_resume_addr", avm_address, BASE + 32'd8);
    step();
    chk1("t3_nogap_valid", instr_valid, 1'b1);
    chk ("t3_nogap_pc", instr_pc, BASE + 32'd8);
    step();
    chk ("t3_pc3", instr_pc, BASE + 32'hC);

    // Redirect during a stalled request
    apply_reset();
    step();
    avm_waitrequest = 1'b1;
    step();
    chk ("t4_stall_addr", avm_address, BASE);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0010;
    step();
    redirect_valid = 1'b0;
    chk1("t4_drain_read", avm_read, 1'b1);
    chk ("t4_drain_addr", avm_address, BASE);
    chk1("t4_drain_valid", instr_valid, 1'b0);
    step();
    chk ("t4_drain_addr2", avm_address, BASE);
    avm_waitrequest = 1'b0;
    step();
    chk ("t4_new_addr", avm_address, 32'h0040_0010);
    chk1("t4_new_read", avm_read, 1'b1);
    chk1("t4_discard_valid", instr_valid, 1'b0);
    step();
    chk1("t4_valid", instr_valid, 1'b1);
    chk ("t4_pc", instr_pc, 32'h0040_0010);
    chk ("t4_instr", instr, mem_word(32'h0040_0010));

    // Redirect coincident with pop and accept; unaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0013;
    step();
    redirect_valid = 1'b0;
    chk1("t5_flush_valid", instr_valid, 1'b0);
    chk ("t5_addr", avm_address, 32'h0040_0010);
    chk1("t5_read", avm_read, 1'b1);
    step();
    chk1("t5_valid", instr_valid, 1'b1);
    chk ("t5_pc", instr_pc, 32'h0040_0010);
    step();
    chk ("t5_pc2", instr_pc, 32'h0040_0014);
    chk ("t5_addr2", avm_address, 32'h0040_0018);

    // Redirect to 0 with a request in flight
    avm_waitrequest = 1'b1;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0;
    step();
    redirect_valid  = 1'b0;
    avm_waitrequest = 1'b0;
    chk1("t6_drain_read", avm_read, 1'b1);
    chk ("t6_drain_addr", avm_address, 32'h0040_0018);
    chk1("t6_not_halted", halted, 1'b0);
    chk1("t6_flush_valid", instr_valid, 1'b0);
    step();
    chk1("t6_halted", halted, 1'b1);
    chk1("t6_read", avm_read, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0000;
    for (int unsigned i = 0; i < 20; i++) begin
      step();
      redirect_valid = 1'b0;
      chk1("t6_halt_read", avm_read, 1'b0);
      chk1("t6_halt_sticky", halted, 1'b1);
      chk1("t6_halt_valid", instr_valid, 1'b0);
    end

    // Reset asserted mid-request
    apply_reset();
    step();
    avm_waitrequest = 1'b1;
    step();
    chk1("t7_req_read", avm_read, 1'b1);
    reset_n = 1'b0;
    #1;
    chk1("t7_async_read", avm_read, 1'b0);
    chk ("t7_async_addr", avm_address, BASE);
    chk1("t7_async_halted", halted, 1'b0);
    avm_waitrequest = 1'b0;
    step();
    reset_n = 1'b1;
    chk1("t7_idle_read", avm_read, 1'b0);
    chk1("t7_idle_valid", instr_valid, 1'b0);
    step();
    chk1("t7_refetch_read", avm_read, 1'b1);
    chk ("t7_refetch_addr", avm_address, BASE);
    step();
    chk1("t7_valid", instr_valid, 1'b1);
    chk ("t7_pc", instr_pc, BASE);
    chk ("t7_instr", instr, mem_word(BASE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
